quad_demod_lpf: RTL

QUAD_DEMOD_LPF -- requirements
Module: quad_demod_lpf

---
 rtl/quad_demod_pkg.sv | 27 ++
 rtl/quad_demod_lpf_if.sv | 11 +
 rtl/quad_sin_lut.sv | 50 +++++
 rtl/quad_demod_lpf.sv | 99 +++++++++
 4 files changed

// File: rtl/quad_demod_pkg.sv
// Shared widths and elaboration-time helpers for the quadrature demodulator.
// qsin() builds the quarter-wave table contents without any real-number math.
package quad_demod_pkg;
  localparam int REF_W    = 16;
  localparam int OUT_W    = 33;
  localparam int PIPE_LAT = 4;
  localparam int LUT_AW   = 10;

  function automatic int acc_w(input int log2_n);
    return 32 + log2_n;
  endfunction

  // round(32767*sin(pi/2 * i/1024)) via a Q30 Horner-form Taylor series to x^11
  function automatic logic [REF_W-1:0] qsin(input int i);
    longint one, x, x2, t;
    one = longint'(1) << 30;
    x   = (longint'(i) * 64'sd1686629713) >>> 10;
    x2  = (x * x) >>> 30;
    t   = one - (x2 / 110);
    t   = one - (((x2 * t) >>> 30) / 72);
    t   = one - (((x2 * t) >>> 30) / 42);
    t   = one - (((x2 * t) >>> 30) / 20);
    t   = one - (((x2 * t) >>> 30) / 6);
    t   = (x * t) >>> 30;
    return REF_W'((t * 32767 + (longint'(1) << 29)) >>> 30);
  endfunction
endpackage

// File: rtl/quad_demod_lpf_if.sv
// Sample-in / filtered-result-out bundle of the quadrature demodulator.
interface quad_demod_lpf_if #(parameter int IN_W = 16);
  logic                                    s_tvalid;
  logic signed [IN_W-1:0]                  s_tdata;
  logic signed [quad_demod_pkg::OUT_W-1:0] fil_sin_o;
  logic signed [quad_demod_pkg::OUT_W-1:0] fil_cos_o;
  logic                                    out_valid;

  modport master (output s_tvalid, s_tdata, input fil_sin_o, fil_cos_o, out_valid);
  modport slave  (input s_tvalid, s_tdata, output fil_sin_o, fil_cos_o, out_valid);
endinterface

// File: rtl/quad_sin_lut.sv
// Quarter-wave sin table with quadrant folding; phase[11:10] quadrant,
// phase[9:0] table address; registered sin/cos, one-cycle latency.
module quad_sin_lut import quad_demod_pkg::*; (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [LUT_AW+1:0]       phase,
  output logic signed [REF_W-1:0] sin_ref,
  output logic signed [REF_W-1:0] cos_ref
);
  localparam int QW = 1 << LUT_AW;
  localparam logic signed [REF_W-1:0] FULL = {1'b0, {(REF_W-1){1'b1}}};

  logic signed [REF_W-1:0] rom [QW];
  for (genvar g = 0; g < QW; g++) begin : g_rom
    localparam logic signed [REF_W-1:0] V = qsin(g);
    assign rom[g] = V;
  end

  logic [1:0]              quad;
  logic [LUT_AW-1:0]       addr, addr_n;
  logic signed [REF_W-1:0] sin_mag, cos_mag, sin_nxt, cos_nxt;

  assign quad    = phase[LUT_AW+1:LUT_AW];
  assign addr    = phase[LUT_AW-1:0];
  assign addr_n  = ~addr + LUT_AW'(1);
  assign sin_mag = rom[addr];
  // cos(0) would need entry 1024, one past the table end
  assign cos_mag = (addr == '0) ? FULL : rom[addr_n];

  always_comb begin
    sin_nxt = sin_mag;
    cos_nxt = cos_mag;
    unique case (quad)
      2'd0: begin sin_nxt =  sin_mag; cos_nxt =  cos_mag; end
      2'd1: begin sin_nxt =  cos_mag; cos_nxt = -sin_mag; end
      2'd2: begin sin_nxt = -sin_mag; cos_nxt = -cos_mag; end
      2'd3: begin sin_nxt = -cos_mag; cos_nxt =  sin_mag; end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sin_ref <= '0;
      cos_ref <= '0;
    end else begin
      sin_ref <= sin_nxt;
      cos_ref <= cos_nxt;
    end
  end
endmodule

// File: rtl/quad_demod_lpf.sv
// Quadrature mixer against an NCO reference followed by an N-sample
// accumulate-and-dump low-pass; outputs 2*mean of each mixed product.
module quad_demod_lpf import quad_demod_pkg::*; #(
  parameter int IN_W   = 16,
  parameter int LOG2_N = 10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] phase_inc,
  input  logic        clear,
  quad_demod_lpf_if.slave io
);
  localparam int AW     = acc_w(LOG2_N);
  localparam int PROD_W = 32;

  logic [PIPE_LAT-1:1]      vld_pipe;
  logic [31:0]              phase_acc;
  logic [LUT_AW+1:0]        phase_s1;
  logic signed [IN_W-1:0]   x_s1, x_s2;
  logic signed [REF_W-1:0]  sin_ref, cos_ref;
  logic signed [PROD_W-1:0] prod_sin, prod_cos;
  logic signed [AW-1:0]     acc_sin, acc_cos, sum_sin, sum_cos;
  logic [LOG2_N-1:0]        cnt;
  logic signed [OUT_W-1:0]  fil_sin, fil_cos;
  logic                     dump;
  logic                     accept, blk_end;

  // clear beats a coincident sample
  assign accept  = io.s_tvalid && !clear;
  assign blk_end = (cnt == '1);
  assign sum_sin = acc_sin + AW'(prod_sin);
  assign sum_cos = acc_cos + AW'(prod_cos);

  quad_sin_lut u_lut (
    .clk     (clk),
    .rstn    (rstn),
    .phase   (phase_s1),
    .sin_ref (sin_ref),
    .cos_ref (cos_ref)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase_acc <= '0;
      phase_s1  <= '0;
      x_s1      <= '0;
      x_s2      <= '0;
      prod_sin  <= '0;
      prod_cos  <= '0;
      vld_pipe  <= '0;
    end else begin
      if (clear)       phase_acc <= '0;
      else if (accept) phase_acc <= phase_acc + phase_inc;
      if (accept) begin
        phase_s1 <= phase_acc[31:32-(LUT_AW+2)];
        x_s1     <= io.s_tdata;
      end
      x_s2     <= x_s1;
      prod_sin <= PROD_W'(x_s2) * PROD_W'(sin_ref);
      prod_cos <= PROD_W'(x_s2) * PROD_W'(cos_ref);
      vld_pipe <= clear ? '0 : {vld_pipe[PIPE_LAT-2:1], accept};
    end
  end

  // Dump loads zero rather than the product so the next block starts clean
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_sin <= '0;
      acc_cos <= '0;
      cnt     <= '0;
      fil_sin <= '0;
      fil_cos <= '0;
      dump    <= 1'b0;
    end else begin
      dump <= 1'b0;
      if (clear) begin
        acc_sin <= '0;
        acc_cos <= '0;
        cnt     <= '0;
      end else if (vld_pipe[PIPE_LAT-1]) begin
        cnt <= cnt + LOG2_N'(1);
        if (blk_end) begin
          fil_sin <= OUT_W'(sum_sin >>> (LOG2_N-1));
          fil_cos <= OUT_W'(sum_cos >>> (LOG2_N-1));
          acc_sin <= '0;
          acc_cos <= '0;
          dump    <= 1'b1;
        end else begin
          acc_sin <= sum_sin;
          acc_cos <= sum_cos;
        end
      end
    end
  end

  assign io.fil_sin_o = fil_sin;
  assign io.fil_cos_o = fil_cos;
  assign io.out_valid = dump;
endmodule
